// File: rtl/pc_gen_ras_pkg.sv
// Shared decode constants for the fetch-stage PC generator and its
// return-address stack.
package pc_gen_ras_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] FN_JR    = 6'b001000;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack.
//   clk, rst   : clock, async active-high reset
//   push, pop  : one operation per cycle; push has priority if both are set
//   push_data  : return address to push
//   top        : most recently pushed entry (undefined while empty)
//   empty/full : occupancy status
// ptr_q always points at the next slot to write. When the stack is full
// that slot holds the oldest entry, so a push overwrites it naturally and
// the count saturates.
module pc_ras #(
  parameter int RAS_DEPTH = 4,
  parameter int PC_W      = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PC_W-1:0]  mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] top_idx;

  assign top_idx = ptr_q - PTR_W'(1);
  assign top     = mem_q[top_idx];
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(RAS_DEPTH));

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (!full) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop && !empty) begin
      ptr_d = ptr_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry contents need no reset; validity is tracked by cnt_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[ptr_q] <= push_data;
  end

endmodule

// File: rtl/pc_gen_ras.sv
// Fetch-stage program-counter generator with return-address prediction.
//   clk, rst        : clock, async active-high reset
//   en              : 1 = advance, 0 = stall (pc, RAS and flags held)
//   instr_valid     : instr is the word fetched at pc
//   instr, zf       : fetched instruction and BEQ zero flag
//   redirect_valid  : later-stage correction, wins over everything incl. stall
//   redirect_pc     : corrected PC
//   pc              : current word-addressed PC
//   ras_empty       : RAS has no valid entries
//   ras_overflow    : sticky, a JAL pushed onto a full RAS
//   ras_underflow   : sticky, a JR found the RAS empty
module pc_gen_ras
  import pc_gen_ras_pkg::*;
#(
  parameter int              PC_W      = 32,
  parameter int              RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  input  logic            zf,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [PC_W-1:0] pc,
  output logic            ras_empty,
  output logic            ras_overflow,
  output logic            ras_underflow
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;

  logic [5:0]      op, funct;
  logic            is_beq, is_j, is_jal, is_jr;
  logic            advance, ras_push, ras_pop;
  logic [PC_W-1:0] inc, br_off, jtarget, ras_top;
  logic            ras_full;

  assign op     = instr[31:26];
  assign funct  = instr[5:0];
  assign is_beq = (op == OP_BEQ);
  assign is_j   = (op == OP_J);
  assign is_jal = (op == OP_JAL);
  assign is_jr  = (op == OP_RTYPE) && (funct == FN_JR);

  assign inc    = pc_q + PC_W'(1);
  assign br_off = {{(PC_W-16){instr[15]}}, instr[15:0]};

  // At PC_W=26 the jump target has no upper PC bits to keep.
  if (PC_W > 26) begin : g_jhi
    assign jtarget = {pc_q[PC_W-1:26], instr[25:0]};
  end else begin : g_jlo
    assign jtarget = instr[25:0];
  end

  // The RAS only moves when an instruction is actually retired from fetch.
  assign advance  = en && !redirect_valid && instr_valid;
  assign ras_push = advance && is_jal;
  assign ras_pop  = advance && is_jr && !ras_empty;

  pc_ras #(
    .RAS_DEPTH (RAS_DEPTH),
    .PC_W      (PC_W)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (inc),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  always_comb begin
    pc_d  = pc_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (en) begin
      if (!instr_valid) begin
        pc_d = inc;
      end else if (is_beq) begin
        pc_d = zf ? (inc + br_off) : inc;
      end else if (is_j || is_jal) begin
        pc_d = jtarget;
        if (is_jal && ras_full) ovf_d = 1'b1;
      end else if (is_jr) begin
        if (ras_empty) begin
          pc_d  = inc;
          unf_d = 1'b1;
        end else begin
          pc_d = ras_top;
        end
      end else begin
        pc_d = inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= RESET_PC;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign pc            = pc_q;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_gen_ras.sv
// Directed test for pc_gen_ras with hand-computed expected values.
module tb_pc_gen_ras;

  logic        clk;
  logic        rst;
  logic        en;
  logic        instr_valid;
  logic [31:0] instr;
  logic        zf;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic        ras_empty;
  logic        ras_overflow;
  logic        ras_underflow;

  int n_checks = 0;
  int n_fail   = 0;

  pc_gen_ras #(
    .PC_W      (32),
    .RAS_DEPTH (4),
    .RESET_PC  (32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .zf             (zf),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc             (pc),
    .ras_empty      (ras_empty),
    .ras_overflow   (ras_overflow),
    .ras_underflow  (ras_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] t);
    return {op, t};
  endfunction

  function automatic logic [31:0] enc_beq(input logic [15:0] imm);
    return {6'b000100, 10'b0, imm};
  endfunction

  localparam logic [31:0] JR  = 32'h0000_0008;
  localparam logic [31:0] NOP = 32'h0000_0000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redir(input logic [31:0] a);
    redirect_valid = 1'b1;
    redirect_pc    = a;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic exec(input logic [31:0] ins, input logic z);
    instr_valid = 1'b1;
    instr       = ins;
    zf          = z;
    tick();
    instr_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; en = 1'b1; instr_valid = 1'b0; instr = '0; zf = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    #12;
    check("rst_pc",  pc, 32'h0);
    check("rst_emp", 32'(ras_empty), 32'd1);
    check("rst_ovf", 32'(ras_overflow), 32'd0);
    check("rst_unf", 32'(ras_underflow), 32'd0);
    rst = 1'b0;

    // Sequential, wrap, and fetch-less advance
    redir(32'hFFFF_FFFF);
    check("redir_max", pc, 32'hFFFF_FFFF);
    exec(NOP, 1'b0);
    check("wrap", pc, 32'h0);
    tick();
    check("seq_nofetch", pc, 32'h1);

    // BEQ with imm = -2
    redir(32'h10);
    exec(enc_beq(16'hFFFE), 1'b1);
    check("beq_taken", pc, 32'h0F);
    redir(32'h10);
    exec(enc_beq(16'hFFFE), 1'b0);
    check("beq_not", pc, 32'h11);

    // Call / return
    redir(32'h20);
    exec(enc_j(6'b000011, 26'h100), 1'b0);
    check("jal_pc",  pc, 32'h100);
    check("jal_emp", 32'(ras_empty), 32'd0);
    exec(JR, 1'b0);
    check("jr_pc",  pc, 32'h21);
    check("jr_emp", 32'(ras_empty), 32'd1);

    // Plain J keeps upper PC bits and leaves RAS alone
    redir(32'hA000_0005);
    exec(enc_j(6'b000010, 26'h0123), 1'b0);
    check("j_pc",  pc, 32'hA000_0123);
    check("j_emp", 32'(ras_empty), 32'd1);

    // Priority: stall, then redirect during stall
    redir(32'h30);
    en = 1'b0;
    exec(enc_j(6'b000011, 26'h200), 1'b0);
    check("stall_pc",  pc, 32'h30);
    check("stall_emp", 32'(ras_empty), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    exec(enc_j(6'b000011, 26'h200), 1'b0);
    redirect_valid = 1'b0;
    check("redir_stall_pc",  pc, 32'h80);
    check("redir_stall_emp", 32'(ras_empty), 32'd1);
    en = 1'b1;

    // Overflow then underflow on a 4-deep RAS
    redir(32'h1);
    for (int i = 1; i <= 5; i++) begin
      exec(enc_j(6'b000011, 26'(i + 1)), 1'b0);
      check($sformatf("nest_jal%0d", i), pc, 32'(i + 1));
    end
    check("ovf_set",  32'(ras_overflow), 32'd1);
    check("unf_clr",  32'(ras_underflow), 32'd0);
    begin
      logic [31:0] ret_exp [5] = '{32'h6, 32'h5, 32'h4, 32'h3, 32'h4};
      for (int i = 0; i < 5; i++) begin
        exec(JR, 1'b0);
        check($sformatf("ret%0d", i), pc, ret_exp[i]);
      end
    end
    check("unf_set", 32'(ras_underflow), 32'd1);
    check("ovf_hold", 32'(ras_overflow), 32'd1);
    check("ret_emp", 32'(ras_empty), 32'd1);
    en = 1'b0;
    tick();
    check("stall_flags", {30'b0, ras_overflow, ras_underflow}, 32'd3);
    en = 1'b1;

    // Async reset mid-run with two RAS entries
    redir(32'h10);
    exec(enc_j(6'b000011, 26'h11), 1'b0);
    exec(enc_j(6'b000011, 26'h40), 1'b0);
    check("pre_rst_pc",  pc, 32'h40);
    check("pre_rst_emp", 32'(ras_empty), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("arst_pc",  pc, 32'h0);
    check("arst_emp", 32'(ras_empty), 32'd1);
    check("arst_ovf", 32'(ras_overflow), 32'd0);
    check("arst_unf", 32'(ras_underflow), 32'd0);
    #10 rst = 1'b0;
    tick();
    check("post_rst_seq", pc, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
